mem_bus_responder: RTL and testbench

Memory-side end of the CPU external bus: decodes the multiplexed 64-bit address/data protocol (nME, nALE, RnW, nOE) driven by one CPU core port. It latches the address, serves reads from an internal 64-bit word array after a fixed latency, and commits writes. One instance sits on each core's Data/control bus in the system testbench or SoC top. The top-level tristate is built outside, from Data_out and ENB.

---
 rtl/mem_bus_pkg.sv | 16 +
 rtl/mem_bus_ram.sv | 32 +++
 rtl/mem_bus_responder.sv | 138 +++++++++++++
 tb/tb_mem_bus_responder.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and widths for the external memory bus responder and its RAM.
package mem_bus_pkg;

  localparam int BUS_W  = 64;
  localparam int OFFS_W = 3;
  localparam int CNT_W  = 4;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    RWAIT,
    RDRIVE,
    WDONE
  } state_t;

endpackage

// File: rtl/mem_bus_ram.sv
// Single-port word RAM with a registered read port; the array itself is never reset.
module mem_bus_ram
  import mem_bus_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [BUS_W-1:0] wdata,
  output logic [BUS_W-1:0] rdata
);

  logic [BUS_W-1:0] mem_q [DEPTH];
  logic [BUS_W-1:0] rdata_q;
  logic [BUS_W-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[addr];
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder for the multiplexed CPU bus: address decode, latency-timed
// read drive and single-shot write commit into an internal word array.
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int               DEPTH        = 1024,
  parameter logic [BUS_W-1:0] BASE_ADDR    = 64'h0,
  parameter int               READ_LATENCY = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [BUS_W-1:0] Data_in,
  output logic [BUS_W-1:0] Data_out,
  output logic             ENB,
  input  logic             nME,
  input  logic             nALE,
  input  logic             RnW,
  input  logic             nOE,
  output logic             Hit,
  output logic             Busy
);

  localparam int               AW        = $clog2(DEPTH);
  localparam logic [BUS_W-1:0] WIN_BYTES = BUS_W'(DEPTH) << OFFS_W;

  state_t           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             hit_q, hit_d;
  logic             busy_q, busy_d;
  logic             enb_q, enb_d;
  logic [BUS_W-1:0] dout_q, dout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ram_re, ram_we;
  logic [BUS_W-1:0] ram_rdata;
  logic [BUS_W-1:0] offset;

  assign offset = Data_in - BASE_ADDR;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hit_d   = hit_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    enb_d   = 1'b1;
    ram_re  = 1'b0;
    ram_we  = 1'b0;

    // Abort conditions take priority over whatever the current transaction was doing.
    if (state_q == IDLE) begin
      if (!nME && !nALE) begin
        idx_d   = offset[AW+OFFS_W-1:OFFS_W];
        hit_d   = (Data_in >= BASE_ADDR) && (offset < WIN_BYTES);
        state_d = ADDR;
      end
    end else if (nME) begin
      state_d = IDLE;
    end else if (!nALE) begin
      idx_d   = offset[AW+OFFS_W-1:OFFS_W];
      hit_d   = (Data_in >= BASE_ADDR) && (offset < WIN_BYTES);
      state_d = ADDR;
    end else begin
      case (state_q)
        ADDR: begin
          if (hit_q) begin
            if (RnW && !nOE) begin
              ram_re  = 1'b1;
              cnt_d   = CNT_W'(READ_LATENCY - 1);
              state_d = (READ_LATENCY == 1) ? RDRIVE : RWAIT;
            end else if (!RnW) begin
              ram_we  = 1'b1;
              state_d = WDONE;
            end
          end
        end
        RWAIT: begin
          if (!RnW) begin
            state_d = ADDR;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = RDRIVE;
          end
        end
        // Drive is registered, so it appears one edge after RDRIVE is reached.
        RDRIVE: begin
          if (!RnW || nOE) begin
            state_d = ADDR;
          end else begin
            enb_d = 1'b0;
            if (enb_q) dout_d = ram_rdata;
          end
        end
        WDONE:   state_d = WDONE;
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hit_q   <= 1'b0;
      busy_q  <= 1'b0;
      enb_q   <= 1'b1;
      dout_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
      busy_q  <= busy_d;
      enb_q   <= enb_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
    end
  end

  mem_bus_ram #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk  (Clock),
    .we   (ram_we),
    .re   (ram_re),
    .addr (idx_q),
    .wdata(Data_in),
    .rdata(ram_rdata)
  );

  assign Data_out = dout_q;
  assign ENB      = enb_q;
  assign Hit      = hit_q;
  assign Busy     = busy_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench: four responders with different windows/latencies share one bus
// and each is checked against hand-computed expectations.
module tb_mem_bus_responder;

  logic        Clock;
  logic        Reset;
  logic [63:0] dataIn;
  logic        nME, nALE, RnW, nOE;

  logic [63:0] u0Data, u1Data, u2Data, u3Data;
  logic        u0Enb, u1Enb, u2Enb, u3Enb;
  logic        u0Hit, u1Hit, u2Hit, u3Hit;
  logic        u0Busy, u1Busy, u2Busy, u3Busy;

  int testCount = 0;
  int failCount = 0;

  // Default window, latency 2.
  mem_bus_responder u0 (
    .Clock(Clock), .Reset(Reset), .Data_in(dataIn), .Data_out(u0Data), .ENB(u0Enb),
    .nME(nME), .nALE(nALE), .RnW(RnW), .nOE(nOE), .Hit(u0Hit), .Busy(u0Busy)
  );

  // Small window at 0x1000, latency 2.
  mem_bus_responder #(.DEPTH(16), .BASE_ADDR(64'h1000), .READ_LATENCY(2)) u1 (
    .Clock(Clock), .Reset(Reset), .Data_in(dataIn), .Data_out(u1Data), .ENB(u1Enb),
    .nME(nME), .nALE(nALE), .RnW(RnW), .nOE(nOE), .Hit(u1Hit), .Busy(u1Busy)
  );

  // Latency extremes.
  mem_bus_responder #(.DEPTH(16), .BASE_ADDR(64'h0), .READ_LATENCY(1)) u2 (
    .Clock(Clock), .Reset(Reset), .Data_in(dataIn), .Data_out(u2Data), .ENB(u2Enb),
    .nME(nME), .nALE(nALE), .RnW(RnW), .nOE(nOE), .Hit(u2Hit), .Busy(u2Busy)
  );

  mem_bus_responder #(.DEPTH(16), .BASE_ADDR(64'h0), .READ_LATENCY(15)) u3 (
    .Clock(Clock), .Reset(Reset), .Data_in(dataIn), .Data_out(u3Data), .ENB(u3Enb),
    .nME(nME), .nALE(nALE), .RnW(RnW), .nOE(nOE), .Hit(u3Hit), .Busy(u3Busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Drive one bus cycle, let the next rising edge sample it, then settle.
  task automatic applyStimulus(input logic me, input logic ale, input logic rnw,
                               input logic oe, input logic [63:0] d);
    nME    = me;
    nALE   = ale;
    RnW    = rnw;
    nOE    = oe;
    dataIn = d;
    @(posedge Clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic busWrite(input logic [63:0] addr, input logic [63:0] data);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, addr);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, data);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 64'h0);
  endtask

  // Full read on u1 (latency 2): ALE, nOE-low sample, two edges, release.
  task automatic readU1(input logic [63:0] addr, input logic hit, input logic [63:0] data,
                        input string tag);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, addr);
    checkOutput({tag, " hit"}, u1Hit, hit);
    checkOutput({tag, " enb_ale"}, u1Enb, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    checkOutput({tag, " enb_t1"}, u1Enb, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    checkOutput({tag, " enb_t2"}, u1Enb, !hit);
    if (hit) checkOutput({tag, " data"}, u1Data, data);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 64'h0);
    checkOutput({tag, " enb_rel"}, u1Enb, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 64'h0);
  endtask

  initial begin
    Reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 64'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 64'h0);
    checkOutput("rst enb", u1Enb, 1'b1);
    checkOutput("rst data", u1Data, 64'h0);
    checkOutput("rst hit", u1Hit, 1'b0);
    checkOutput("rst busy", u1Busy, 1'b0);
    Reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 64'h0);

    // Write then read 0x40; latency 1/2/15 instances all serve this word.
    busWrite(64'h40, 64'hDEADBEEF_01234567);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 64'h40);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    checkOutput("lat t0 u0 enb", u0Enb, 1'b1);
    checkOutput("lat t0 u2 enb", u2Enb, 1'b1);
    for (int k = 1; k <= 15; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
      checkOutput($sformatf("lat t%0d u0 enb", k), u0Enb, (k >= 2) ? 1'b0 : 1'b1);
      checkOutput($sformatf("lat t%0d u2 enb", k), u2Enb, 1'b0);
      checkOutput($sformatf("lat t%0d u3 enb", k), u3Enb, (k >= 15) ? 1'b0 : 1'b1);
      if (k >= 2) checkOutput($sformatf("lat t%0d u0 data", k), u0Data, 64'hDEADBEEF_01234567);
    end
    checkOutput("lat u2 data", u2Data, 64'hDEADBEEF_01234567);
    checkOutput("lat u3 data", u3Data, 64'hDEADBEEF_01234567);
    checkOutput("lat u0 busy", u0Busy, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 64'h0);
    checkOutput("lat u0 release", u0Enb, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 64'h0);

    // Window edges on u1 (0x1000..0x107F).
    busWrite(64'h1078, 64'hAAAA);
    readU1(64'h1080, 1'b0, 64'h0, "miss_hi");
    readU1(64'h0FF8, 1'b0, 64'h0, "miss_lo");
    busWrite(64'h1007, 64'h11);
    busWrite(64'h1080, 64'hBAD);
    readU1(64'h1078, 1'b1, 64'hAAAA, "miss_wr_last");
    readU1(64'h1000, 1'b1, 64'h11, "align");
    busWrite(64'h1078, 64'hFF);
    readU1(64'h1078, 1'b1, 64'hFF, "last_word");
    readU1(64'h1000, 1'b1, 64'h11, "word0_keep");

    // nME high while waiting for read data.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 64'h1078);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
    checkOutput("abort_me enb", u1Enb, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
    checkOutput("abort_me enb2", u1Enb, 1'b1);
    checkOutput("abort_me busy", u1Busy, 1'b0);

    // New address phase while driving.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 64'h1078);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    checkOutput("abort_ale drive", u1Enb, 1'b0);
    readU1(64'h1000, 1'b1, 64'h11, "abort_ale");

    // Write with nOE low: no drive, only the first data beat lands.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 64'h1008);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 64'h5555);
    checkOutput("contend enb1", u1Enb, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 64'h6666);
    checkOutput("contend enb2", u1Enb, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 64'h0);
    readU1(64'h1008, 1'b1, 64'h5555, "contend_rd");

    // Reset while driving; RAM contents survive.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 64'h1078);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    checkOutput("rst_mid drive", u1Enb, 1'b0);
    Reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    checkOutput("rst_mid enb", u1Enb, 1'b1);
    checkOutput("rst_mid data", u1Data, 64'h0);
    checkOutput("rst_mid busy", u1Busy, 1'b0);
    Reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 64'h0);
    readU1(64'h1078, 1'b1, 64'hFF, "rst_keep");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
